// File: rtl/op_sequencer.sv
// Host-side command issuer for the matrix controller: holds the operation word,
// streams 64-word pages in/out over valid/ready, and inserts the idle gap.
module op_sequencer #(
    parameter int unsigned CELLS      = 64,
    parameter int unsigned MM_HOLD    = 530,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_word,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic        ctrl_enable,
    output logic [31:0] operation,
    output logic [31:0] in_data,
    input  logic [31:0] out_data,
    output logic        busy,
    output logic        done,
    output logic        cmd_err
);
    localparam int unsigned OP_W   = 32;
    localparam int unsigned OPC_W  = 4;
    localparam int unsigned BEAT_W = 7;
    localparam int unsigned HOLD_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_MATMUL,
        S_GAP
    } state_e;

    state_e              state_q, state_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    // Next-state and counter update
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        beat_d  = beat_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_word;
                    beat_d = '0;
                    hold_d = '0;
                    case (cmd_word[OPC_W-1:0])
                        4'd1:    state_d = S_MATMUL;
                        4'd2:    state_d = S_WRITE;
                        4'd3:    state_d = S_READ;
                        default: begin
                            done_d = 1'b1;
                            err_d  = (cmd_word[OPC_W-1:0] > 4'd3);
                        end
                    endcase
                end
            end
            S_WRITE: begin
                if (wr_valid) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_d == BEAT_W'(CELLS)) begin
                        state_d = S_GAP;
                        hold_d  = '0;
                    end
                end
            end
            S_READ: begin
                if (rd_ready) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_d == BEAT_W'(CELLS)) begin
                        state_d = S_GAP;
                        hold_d  = '0;
                    end
                end
            end
            S_MATMUL: begin
                hold_d = hold_q + HOLD_W'(1);
                if (hold_d == HOLD_W'(MM_HOLD)) begin
                    state_d = S_GAP;
                    hold_d  = '0;
                end
            end
            S_GAP: begin
                hold_d = hold_q + HOLD_W'(1);
                if (hold_d == HOLD_W'(GAP_CYCLES)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            beat_q  <= '0;
            hold_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            beat_q  <= beat_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Interface decode; reset forces every output low without waiting for a clock
    always_comb begin
        operation   = '0;
        in_data     = '0;
        rd_data     = '0;
        ctrl_enable = 1'b0;
        cmd_ready   = 1'b0;
        wr_ready    = 1'b0;
        rd_valid    = 1'b0;
        busy        = 1'b0;
        if (!reset) begin
            busy = (state_q != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    ctrl_enable = 1'b1;
                    cmd_ready   = 1'b1;
                end
                S_WRITE: begin
                    operation   = op_q;
                    in_data     = wr_data;
                    wr_ready    = 1'b1;
                    ctrl_enable = wr_valid;
                end
                S_READ: begin
                    operation   = op_q;
                    rd_data     = out_data;
                    rd_valid    = 1'b1;
                    ctrl_enable = rd_ready;
                end
                S_MATMUL: begin
                    operation   = op_q;
                    ctrl_enable = 1'b1;
                end
                S_GAP: ctrl_enable = 1'b1;
                default: ctrl_enable = 1'b0;
            endcase
        end
    end

    assign done    = done_q;
    assign cmd_err = err_q;

endmodule

// File: tb/tb_op_sequencer.sv
// Bench for op_sequencer: command table, directed page/matmul/reset sequences,
// and randomized commands checked against a transaction-level expectation model.
module tb_op_sequencer;
    localparam int unsigned CELLS   = 64;
    localparam int unsigned MM_HOLD = 530;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_word;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid, rd_ready;
    logic [31:0] rd_data;
    logic        ctrl_enable;
    logic [31:0] operation, in_data, out_data;
    logic        busy, done, cmd_err;

    int errors = 0;
    int checks = 0;

    // Controller read-side stand-in: word 100+k, advancing on each enabled read cycle
    logic [6:0] rd_idx;
    always @(posedge clk) begin
        if (operation[3:0] != 4'd3) rd_idx <= '0;
        else if (ctrl_enable)       rd_idx <= rd_idx + 7'd1;
    end
    assign out_data = 32'd100 + 32'(rd_idx);

    op_sequencer dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_word(cmd_word),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .ctrl_enable(ctrl_enable), .operation(operation),
        .in_data(in_data), .out_data(out_data),
        .busy(busy), .done(done), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    typedef struct {
        logic [31:0] word;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [31:0] w);
        cmd_valid = 1'b1;
        cmd_word  = w;
        @(negedge clk);
        check1("accept_cmd_ready", cmd_ready, 1'b1);
        check1("accept_busy", busy, 1'b0);
        tick();
        cmd_valid = 1'b0;
        cmd_word  = $urandom;
    endtask

    // Opcode 0 or illegal: single done pulse, error flag for opcodes above 3
    task automatic simple_resp(input logic exp_done, input logic exp_err);
        @(negedge clk);
        check1("simple_done", done, exp_done);
        check1("simple_err", cmd_err, exp_err);
        check1("simple_busy", busy, 1'b0);
        check1("simple_en", ctrl_enable, 1'b1);
        check32("simple_op", operation, 32'h0);
        tick();
        @(negedge clk);
        check1("simple_done_once", done, 1'b0);
        check1("simple_err_once", cmd_err, 1'b0);
        tick();
    endtask

    // One gap cycle, then the done cycle (optionally offering the next command in it)
    task automatic gap_done(input logic nv, input logic [31:0] nw);
        cmd_valid = 1'($urandom);
        wr_valid  = 1'($urandom);
        rd_ready  = 1'($urandom);
        wr_data   = $urandom;
        @(negedge clk);
        check32("gap_op", operation, 32'h0);
        check1("gap_en", ctrl_enable, 1'b1);
        check1("gap_busy", busy, 1'b1);
        check1("gap_wr_ready", wr_ready, 1'b0);
        check1("gap_rd_valid", rd_valid, 1'b0);
        check32("gap_in_data", in_data, 32'h0);
        check32("gap_rd_data", rd_data, 32'h0);
        check1("gap_done_low", done, 1'b0);
        tick();
        cmd_valid = nv;
        cmd_word  = nw;
        wr_valid  = 1'b0;
        rd_ready  = 1'b0;
        @(negedge clk);
        check1("end_done", done, 1'b1);
        check1("end_err", cmd_err, 1'b0);
        check1("end_busy", busy, 1'b0);
        check1("end_cmd_ready", cmd_ready, 1'b1);
        check32("end_op", operation, 32'h0);
        tick();
        cmd_valid = 1'b0;
        if (!nv) begin
            @(negedge clk);
            check1("end_done_once", done, 1'b0);
            tick();
        end
    endtask

    // mode 0: bubble on every 4th cycle with data 1..64; otherwise random data and stalls
    task automatic write_body(input logic [31:0] word, input int mode);
        logic [31:0] d[CELLS];
        int n = 0;
        int cyc = 0;
        logic wv;
        for (int i = 0; i < int'(CELLS); i++) d[i] = (mode == 0) ? 32'(i + 1) : $urandom;
        while (n < int'(CELLS) && cyc < 1000) begin
            wv        = (mode == 0) ? ((cyc % 4) != 3) : ($urandom_range(0, 2) != 0);
            wr_valid  = wv;
            wr_data   = wv ? d[n] : $urandom;
            cmd_valid = 1'($urandom);
            rd_ready  = 1'($urandom);
            @(negedge clk);
            check32("wr_op", operation, word);
            check1("wr_en", ctrl_enable, wv);
            check1("wr_ready", wr_ready, 1'b1);
            check1("wr_busy", busy, 1'b1);
            if (wv) check32($sformatf("wr_in_data[%0d]", n), in_data, d[n]);
            tick();
            if (wv) n++;
            cyc++;
        end
    endtask

    // mode 0: rd_ready toggles 1/0; otherwise random back-pressure
    task automatic read_body(input logic [31:0] word, input int mode);
        int n = 0;
        int cyc = 0;
        logic rr;
        while (n < int'(CELLS) && cyc < 1000) begin
            rr        = (mode == 0) ? ((cyc % 2) == 0) : 1'($urandom);
            rd_ready  = rr;
            wr_valid  = 1'($urandom);
            cmd_valid = 1'($urandom);
            @(negedge clk);
            check32("rd_op", operation, word);
            check1("rd_valid", rd_valid, 1'b1);
            check1("rd_en", ctrl_enable, rr);
            check1("rd_wr_ready", wr_ready, 1'b0);
            check32("rd_in_data", in_data, 32'h0);
            check32($sformatf("rd_word[%0d]", n), rd_data, 32'(100 + n));
            tick();
            if (rr) n++;
            cyc++;
        end
        check32("rd_beats", 32'(n), 32'(CELLS));
    endtask

    task automatic mm_body(input logic [31:0] word);
        int bad = 0;
        for (int c = 0; c < int'(MM_HOLD); c++) begin
            cmd_valid = 1'($urandom);
            wr_valid  = 1'($urandom);
            rd_ready  = 1'($urandom);
            @(negedge clk);
            if (operation !== word || ctrl_enable !== 1'b1 || busy !== 1'b1 || done !== 1'b0) bad++;
            tick();
        end
        check32("mm_bad_hold_cycles", 32'(bad), 32'h0);
    endtask

    task automatic run_cmd(input logic [31:0] word, input int mode);
        send_cmd(word);
        case (word[3:0])
            4'd1: begin mm_body(word); gap_done(1'b0, 32'h0); end
            4'd2: begin write_body(word, mode); gap_done(1'b0, 32'h0); end
            4'd3: begin read_body(word, mode); gap_done(1'b0, 32'h0); end
            default: simple_resp(1'b1, word[3:0] > 4'd3);
        endcase
    endtask

    initial begin
        vec_t vecs[6];
        int seen;
        logic [31:0] rw;
        logic [3:0]  opc;
        int sel;

        vecs[0] = '{32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{32'h0000_0007, 1'b1, 1'b1};
        vecs[2] = '{32'h0000_0004, 1'b1, 1'b1};
        vecs[3] = '{32'h0000_000F, 1'b1, 1'b1};
        vecs[4] = '{32'hABCD_0000, 1'b1, 1'b0};
        vecs[5] = '{32'h1234_5678, 1'b1, 1'b1};

        reset = 1'b1; cmd_valid = 1'b0; cmd_word = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        #2;
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_en", ctrl_enable, 1'b0);
        check1("rst_cmd_ready", cmd_ready, 1'b0);
        check32("rst_op", operation, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check1("idle_cmd_ready", cmd_ready, 1'b1);
        check1("idle_en", ctrl_enable, 1'b1);
        tick();

        foreach (vecs[i]) begin
            send_cmd(vecs[i].word);
            simple_resp(vecs[i].exp_done, vecs[i].exp_err);
        end

        send_cmd(32'h0000_0022);
        write_body(32'h0000_0022, 0);
        gap_done(1'b0, 32'h0);

        send_cmd(32'h0000_0033);
        read_body(32'h0000_0033, 0);
        gap_done(1'b0, 32'h0);

        // Back-to-back matmuls: second accepted in the first done cycle
        send_cmd(32'h0000_8101);
        mm_body(32'h0000_8101);
        gap_done(1'b1, 32'h0000_8101);
        mm_body(32'h0000_8101);
        gap_done(1'b0, 32'h0);

        // Asynchronous reset in the middle of a write page
        send_cmd(32'h0000_0022);
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'(i + 1);
            tick();
        end
        wr_valid = 1'b1; wr_data = 32'hDEAD_BEEF; rd_ready = 1'b1; cmd_valid = 1'b1;
        #1;
        check32("pre_rst_op", operation, 32'h0000_0022);
        check32("pre_rst_in_data", in_data, 32'hDEAD_BEEF);
        reset = 1'b1;
        #1;
        check32("arst_op", operation, 32'h0);
        check32("arst_in_data", in_data, 32'h0);
        check32("arst_rd_data", rd_data, 32'h0);
        check1("arst_en", ctrl_enable, 1'b0);
        check1("arst_cmd_ready", cmd_ready, 1'b0);
        check1("arst_wr_ready", wr_ready, 1'b0);
        check1("arst_rd_valid", rd_valid, 1'b0);
        check1("arst_busy", busy, 1'b0);
        check1("arst_done", done, 1'b0);
        check1("arst_err", cmd_err, 1'b0);
        tick();
        reset = 1'b0; cmd_valid = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        @(negedge clk);
        check1("post_rst_cmd_ready", cmd_ready, 1'b1);
        check1("post_rst_busy", busy, 1'b0);
        check1("post_rst_en", ctrl_enable, 1'b1);
        check32("post_rst_op", operation, 32'h0);
        tick();
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen++;
            tick();
        end
        check32("post_rst_no_done", 32'(seen), 32'h0);

        // Randomized command mix
        for (int k = 0; k < 10; k++) begin
            rw  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel < 4)       opc = 4'd2;
            else if (sel < 7)  opc = 4'd3;
            else if (sel == 7) opc = 4'd0;
            else if (sel == 8) opc = 4'($urandom_range(4, 15));
            else               opc = 4'd1;
            run_cmd({rw[31:4], opc}, 1);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                check1("rand_idle_busy", busy, 1'b0);
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/op_sequencer.md
Name: op_sequencer

Overview:
- Host-side issuer for the matrix controller's `operation`/`in_data`/`out_data` interface.
- Accepts whole commands, each encoded exactly like the controller's 32-bit `operation` word.
- Drives the operation word for the correct number of cycles and streams 64-word pages in (opcode 2) or out (opcode 3) over valid/ready.
- Inserts the mandatory idle gap between commands.
- Uses the controller's global `enable` as its stall mechanism.

Parameters:
- CELLS, 64, words per page (8x8); serial write/read beat count.
- MM_HOLD, 530, cycles `operation` is held with opcode 1 before the gap.
- GAP_CYCLES, 1, cycles of opcode 0 (`enable` high) after every non-idle command.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_word  in  32  command, controller operation encoding (`[3:0]` opcode).
- wr_valid  in  1  write-stream word offered.
- wr_ready  out  1  write-stream word consumed this cycle.
- wr_data  in  32  write-stream word.
- rd_valid  out  1  read-stream word presented.
- rd_ready  in  1  read-stream consumer accepts.
- rd_data  out  32  read-stream word.
- ctrl_enable  out  1  to controller `enable`.
- operation  out  32  to controller `operation`.
- in_data  out  32  to controller `in_data`.
- out_data  in  32  from controller `out_data`.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse, command completed.
- cmd_err  out  1  one-cycle pulse with `done`, command opcode was greater than 3.

Behaviour:
- Reset:
  - While `reset` is high, every output is 0: `operation`, `in_data`, `ctrl_enable`, `cmd_ready`, `wr_ready`, `rd_valid`, `rd_data`, `busy`, `done`, `cmd_err`.
  - State goes to IDLE and all counters clear.
  - Reset mid-command abandons the command silently; no `done` is produced.
- States: IDLE, WRITE, READ, MATMUL, GAP.
  - Command register `op_q` (32 bits).
  - Beat counter (7 bits, 0..CELLS).
  - Hold counter (16 bits).
- IDLE:
  - `operation=0`, `ctrl_enable=1`, `cmd_ready=1`.
  - On `cmd_valid & cmd_ready`: `op_q<=cmd_word`, counters clear.
  - Next state by opcode: 1 -> MATMUL; 2 -> WRITE; 3 -> READ.
  - Opcode 0 -> stay IDLE, `done` pulses next cycle.
  - Opcode 4..15 -> stay IDLE, `done` and `cmd_err` pulse next cycle.
- WRITE:
  - `operation=op_q`, `in_data=wr_data`, `wr_ready=1`, `ctrl_enable=wr_valid`.
  - Each cycle with `wr_valid` high is one beat and increments the beat counter.
  - With `wr_valid` low, the controller is frozen and the counter holds.
  - After beat CELLS (counter reaches CELLS on that edge) -> GAP.
  - `wr_ready` is 0 in every state other than WRITE.
- READ:
  - `operation=op_q`, `rd_data=out_data` (combinational), `rd_valid=1`, `ctrl_enable=rd_ready`.
  - A beat is `rd_valid & rd_ready`. No stall or back-pressure loses or duplicates a word.
  - After beat CELLS -> GAP.
- MATMUL:
  - `operation=op_q`, `ctrl_enable=1` unconditionally.
  - Hold counter increments each cycle. After MM_HOLD cycles in MATMUL -> GAP.
- GAP:
  - `operation=0`, `ctrl_enable=1`, for GAP_CYCLES cycles.
  - Then -> IDLE, with `done` high in the first IDLE cycle.
  - The gap guarantees the controller sees a fresh opcode-1 rising edge on back-to-back matmuls.
- Throughput: a new command may be accepted in the same IDLE cycle that `done` is high.
- Inputs ignored: `cmd_valid` in non-IDLE states; `wr_valid` outside WRITE; `rd_ready` outside READ.
- `in_data` is 0 outside WRITE; `rd_data` is 0 outside READ.
- `busy = (state != IDLE)`.

Test Plan:
- Reset asserted mid-WRITE at beat 10 -> all outputs 0 immediately (async); after release, IDLE with `cmd_ready=1`; no `done` pulse.
- Write command `0x00000022`, wr_data 1..64 with `wr_valid` low on every 4th cycle -> exactly 64 enabled cycles carry `in_data` 1..64 in order; `ctrl_enable=0` on each bubble; `operation=0x22` throughout; then 1 gap cycle with `operation=0`; `done` pulses once.
- Read command `0x00000033`, out_data model returns 100+index advancing on `ctrl_enable`, `rd_ready` toggling 1/0 -> consumer receives 100..163 with no gaps or repeats; exactly 64 accepted beats; then GAP; then `done`.
- Two back-to-back matmul commands `0x00008101` -> each holds `operation` for exactly 530 cycles; exactly 1 cycle of `operation=0` between them; `done` pulses twice; second accepted on the first `done` cycle.
- Command `0x00000007` -> no state change; `done` and `cmd_err` high together for one cycle; `ctrl_enable` stays 1; `operation` stays 0.
- Command `0x00000000` -> `done=1`, `cmd_err=0`, one cycle; `busy` never asserts.
